// File: rtl/interconnect_pkg.sv
// Shared types and default-configuration constants for the PE <-> memory-bank crossbar.
package interconnect_pkg;

    localparam int N_BANKS_DEF     = 8;
    localparam int BANK_ADDR_L_DEF = 10;
    localparam int BANK_ID_L       = $clog2(N_BANKS_DEF);
    localparam int GADDR_L         = BANK_ADDR_L_DEF + BANK_ID_L;
    // Requester ids are carried at a fixed width so the tag type is configuration independent.
    localparam int PE_ID_MAX_L     = 8;

    typedef enum logic {
        MODE_ST_PRIO = 1'b0,
        MODE_FAIR    = 1'b1
    } arb_mode_e;

    typedef struct packed {
        logic                   vld;
        logic [PE_ID_MAX_L-1:0] pe_id;
        logic                   init;
    } resp_tag_t;

endpackage

// File: rtl/xbar_bank_arbiter.sv
// Round-robin arbiter for one bank; slots are ordered {st0,ld0,st1,ld1,...}.
module xbar_bank_arbiter
    import interconnect_pkg::*;
#(
    parameter  int N_SLOT = 32,
    localparam int SLOT_L = $clog2(N_SLOT)
) (
    input  logic [N_SLOT-1:0] req,
    input  arb_mode_e         mode,
    input  logic [SLOT_L-1:0] ptr,
    output logic [N_SLOT-1:0] gnt,
    output logic [SLOT_L-1:0] win,
    output logic              gnt_any
);

    logic [N_SLOT-1:0] st_mask;
    logic [N_SLOT-1:0] req_m;

    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_mask
        assign st_mask[gi] = (gi % 2 == 0) ? 1'b1 : 1'b0;
    end

    always_comb begin
        int idx;
        idx   = 0;
        req_m = req;
        // Store-priority mode narrows the candidate set before the shared RR scan.
        if (mode == MODE_ST_PRIO) begin
            req_m = (|(req & st_mask)) ? (req & st_mask) : (req & ~st_mask);
        end
        gnt     = '0;
        win     = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N_SLOT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_SLOT) begin
                idx = idx - N_SLOT;
            end
            if (!gnt_any && req_m[idx]) begin
                gnt_any = 1'b1;
                win     = SLOT_L'(idx);
            end
        end
        if (gnt_any) begin
            gnt[win] = 1'b1;
        end
    end

endmodule

// File: rtl/interconnect_xbar_gen.sv
// PE <-> global-memory-bank crossbar: address decode, per-bank arbitration and muxing,
// fixed-latency response tag pipe with output demux, and the init/debug access port.
module interconnect_xbar_gen
    import interconnect_pkg::*;
#(
    parameter  int N_PE        = 16,
    parameter  int N_BANKS     = 8,
    parameter  int DATA_L      = 32,
    parameter  int BANK_ADDR_L = 10,
    parameter  int BANK_ID_LSB = 0,
    parameter  int MEM_RD_LAT  = 1,
    parameter  int ST_PRIO     = 1,
    localparam int BID_L       = $clog2(N_BANKS),
    localparam int GA_L        = BANK_ADDR_L + BID_L,
    localparam int N_SLOT      = 2 * N_PE,
    localparam int SLOT_L      = $clog2(N_SLOT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PE*GA_L-1:0]       ld_addr,
    input  logic [N_PE-1:0]            ld_req,
    output logic [N_PE-1:0]            ld_gnt,
    output logic [N_PE*DATA_L-1:0]     ld_data,
    output logic [N_PE-1:0]            ld_data_vld,
    input  logic [N_PE*GA_L-1:0]       st_addr,
    input  logic [N_PE*DATA_L-1:0]     st_data,
    input  logic [N_PE-1:0]            st_req,
    output logic [N_PE-1:0]            st_gnt,
    output logic [N_BANKS*BANK_ADDR_L-1:0] mem_addr,
    output logic [N_BANKS*DATA_L-1:0]  mem_wr_data,
    output logic [N_BANKS-1:0]         mem_wr_en,
    output logic [N_BANKS-1:0]         mem_rd_en,
    input  logic [N_BANKS*DATA_L-1:0]  mem_rd_data,
    input  logic [GA_L-1:0]            init_mem_addr,
    input  logic                       init_mem_vld,
    input  logic                       init_mem_wr_en,
    input  logic [DATA_L-1:0]          init_mem_wr_data,
    output logic [DATA_L-1:0]          init_mem_rd_data,
    output logic                       init_mem_rd_data_vld
);

    localparam arb_mode_e ARB_MODE = (ST_PRIO != 0) ? MODE_ST_PRIO : MODE_FAIR;

    function automatic logic [BID_L-1:0] bank_of(input logic [GA_L-1:0] a);
        return a[BANK_ID_LSB +: BID_L];
    endfunction

    // Bank address is every non-bank-id bit, kept in its original order.
    function automatic logic [BANK_ADDR_L-1:0] baddr_of(input logic [GA_L-1:0] a);
        logic [BANK_ADDR_L-1:0] r;
        int j;
        r = '0;
        j = 0;
        for (int b = 0; b < GA_L; b++) begin
            if (b < BANK_ID_LSB || b >= BANK_ID_LSB + BID_L) begin
                r[j] = a[b];
                j++;
            end
        end
        return r;
    endfunction

    logic [BID_L-1:0]       ld_bank  [N_PE];
    logic [BID_L-1:0]       st_bank  [N_PE];
    logic [BANK_ADDR_L-1:0] ld_baddr [N_PE];
    logic [BANK_ADDR_L-1:0] st_baddr [N_PE];
    logic [DATA_L-1:0]      st_dat   [N_PE];
    logic [DATA_L-1:0]      ld_data_w   [N_PE];
    logic [DATA_L-1:0]      ld_data_reg [N_PE];
    logic [N_SLOT-1:0]      bank_gnt [N_BANKS];
    resp_tag_t              tail     [N_BANKS];
    logic [DATA_L-1:0]      init_rd_data_reg;
    logic                   run;
    logic                   init_go;
    logic [BID_L-1:0]       init_bank;
    logic [BANK_ADDR_L-1:0] init_baddr;

    // Grants are suppressed during reset and whenever the init port owns the banks.
    assign run        = rst & ~init_mem_vld;
    assign init_go    = rst & init_mem_vld;
    assign init_bank  = bank_of(init_mem_addr);
    assign init_baddr = baddr_of(init_mem_addr);

    for (genvar gi = 0; gi < N_PE; gi++) begin : g_pe
        assign ld_bank[gi]  = bank_of(ld_addr[gi*GA_L +: GA_L]);
        assign st_bank[gi]  = bank_of(st_addr[gi*GA_L +: GA_L]);
        assign ld_baddr[gi] = baddr_of(ld_addr[gi*GA_L +: GA_L]);
        assign st_baddr[gi] = baddr_of(st_addr[gi*GA_L +: GA_L]);
        assign st_dat[gi]   = st_data[gi*DATA_L +: DATA_L];
        assign ld_data[gi*DATA_L +: DATA_L] = ld_data_w[gi];
    end

    for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
        logic [N_SLOT-1:0]      req;
        logic [N_SLOT-1:0]      gnt;
        logic [SLOT_L-1:0]      win;
        logic                   gnt_any;
        logic [SLOT_L-1:0]      ptr_reg;
        logic [SLOT_L-2:0]      pe;
        logic [BANK_ADDR_L-1:0] b_addr;
        logic [DATA_L-1:0]      b_wr_data;
        logic                   b_wr_en;
        logic                   b_rd_en;
        resp_tag_t              tag_in;
        resp_tag_t              pipe_reg [MEM_RD_LAT];

        for (genvar gj = 0; gj < N_PE; gj++) begin : g_slot
            assign req[2*gj]   = run & st_req[gj] & (st_bank[gj] == BID_L'(gi));
            assign req[2*gj+1] = run & ld_req[gj] & (ld_bank[gj] == BID_L'(gi));
        end

        xbar_bank_arbiter #(.N_SLOT(N_SLOT)) u_arb (
            .req     (req),
            .mode    (ARB_MODE),
            .ptr     (ptr_reg),
            .gnt     (gnt),
            .win     (win),
            .gnt_any (gnt_any)
        );

        assign pe = win[SLOT_L-1:1];

        always_comb begin
            b_addr    = '0;
            b_wr_data = '0;
            b_wr_en   = 1'b0;
            b_rd_en   = 1'b0;
            tag_in    = '0;
            if (init_go && init_bank == BID_L'(gi)) begin
                b_addr      = init_baddr;
                b_wr_data   = init_mem_wr_data;
                b_wr_en     = init_mem_wr_en;
                b_rd_en     = ~init_mem_wr_en;
                tag_in.vld  = ~init_mem_wr_en;
                tag_in.init = 1'b1;
            end else if (gnt_any) begin
                if (win[0]) begin
                    b_addr       = ld_baddr[pe];
                    b_rd_en      = 1'b1;
                    tag_in.vld   = 1'b1;
                    tag_in.pe_id = PE_ID_MAX_L'(pe);
                end else begin
                    b_addr    = st_baddr[pe];
                    b_wr_data = st_dat[pe];
                    b_wr_en   = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ptr_reg <= '0;
                for (int s = 0; s < MEM_RD_LAT; s++) begin
                    pipe_reg[s] <= '0;
                end
            end else begin
                if (gnt_any) begin
                    ptr_reg <= (win == SLOT_L'(N_SLOT - 1)) ? '0 : win + 1'b1;
                end
                pipe_reg[0] <= tag_in;
                for (int s = 1; s < MEM_RD_LAT; s++) begin
                    pipe_reg[s] <= pipe_reg[s-1];
                end
            end
        end

        assign bank_gnt[gi] = gnt;
        assign tail[gi]     = pipe_reg[MEM_RD_LAT-1];
        assign mem_addr[gi*BANK_ADDR_L +: BANK_ADDR_L] = b_addr;
        assign mem_wr_data[gi*DATA_L +: DATA_L]        = b_wr_data;
        assign mem_wr_en[gi] = b_wr_en;
        assign mem_rd_en[gi] = b_rd_en;
    end

    always_comb begin
        ld_gnt = '0;
        st_gnt = '0;
        for (int p = 0; p < N_PE; p++) begin
            for (int b = 0; b < N_BANKS; b++) begin
                st_gnt[p] = st_gnt[p] | bank_gnt[b][2*p];
                ld_gnt[p] = ld_gnt[p] | bank_gnt[b][2*p+1];
            end
        end
    end

    // Tail of each bank pipe steers that bank's read data; otherwise outputs hold last value.
    always_comb begin
        ld_data_vld          = '0;
        init_mem_rd_data_vld = 1'b0;
        init_mem_rd_data     = init_rd_data_reg;
        for (int p = 0; p < N_PE; p++) begin
            ld_data_w[p] = ld_data_reg[p];
        end
        for (int b = 0; b < N_BANKS; b++) begin
            if (tail[b].vld && tail[b].init) begin
                init_mem_rd_data_vld = 1'b1;
                init_mem_rd_data     = mem_rd_data[b*DATA_L +: DATA_L];
            end
            for (int p = 0; p < N_PE; p++) begin
                if (tail[b].vld && !tail[b].init && tail[b].pe_id == PE_ID_MAX_L'(p)) begin
                    ld_data_vld[p] = 1'b1;
                    ld_data_w[p]   = mem_rd_data[b*DATA_L +: DATA_L];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_rd_data_reg <= '0;
            for (int p = 0; p < N_PE; p++) begin
                ld_data_reg[p] <= '0;
            end
        end else begin
            init_rd_data_reg <= init_mem_rd_data;
            for (int p = 0; p < N_PE; p++) begin
                ld_data_reg[p] <= ld_data_w[p];
            end
        end
    end

endmodule

// File: tb/tb_interconnect_xbar_gen.sv
// Directed bench: store-priority crossbar plus a fair-mode twin, both 16 PEs x 8 banks, read latency 2.
module tb_interconnect_xbar_gen;

    localparam int NP = 16;
    localparam int NB = 8;
    localparam int DL = 32;
    localparam int BA = 10;
    localparam int GA = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*GA-1:0]  ld_addr, st_addr;
    logic [NP-1:0]     ld_req, st_req;
    logic [NP*DL-1:0]  st_data;
    logic [NB*DL-1:0]  mem_rd_data, zero_rd_data;
    logic [GA-1:0]     init_mem_addr;
    logic              init_mem_vld, init_mem_wr_en;
    logic [DL-1:0]     init_mem_wr_data;

    logic [NP-1:0]     ld_gnt, st_gnt, ld_data_vld;
    logic [NP*DL-1:0]  ld_data;
    logic [NB*BA-1:0]  mem_addr;
    logic [NB*DL-1:0]  mem_wr_data;
    logic [NB-1:0]     mem_wr_en, mem_rd_en;
    logic [DL-1:0]     init_mem_rd_data;
    logic              init_mem_rd_data_vld;

    logic [NP-1:0]     f_ld_gnt, f_st_gnt, f_ld_data_vld;
    logic [NP*DL-1:0]  f_ld_data;
    logic [NB*BA-1:0]  f_mem_addr;
    logic [NB*DL-1:0]  f_mem_wr_data;
    logic [NB-1:0]     f_mem_wr_en, f_mem_rd_en;
    logic [DL-1:0]     f_init_mem_rd_data;
    logic              f_init_mem_rd_data_vld;

    logic [DL-1:0]     mem [NB][1024];
    logic [DL-1:0]     s0 [NB];
    logic [DL-1:0]     s1 [NB];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    interconnect_xbar_gen #(.N_PE(NP), .N_BANKS(NB), .DATA_L(DL), .BANK_ADDR_L(BA),
                            .BANK_ID_LSB(0), .MEM_RD_LAT(2), .ST_PRIO(1)) dut (
        .clk(clk), .rst(rst), .ld_addr(ld_addr), .ld_req(ld_req), .ld_gnt(ld_gnt),
        .ld_data(ld_data), .ld_data_vld(ld_data_vld), .st_addr(st_addr), .st_data(st_data),
        .st_req(st_req), .st_gnt(st_gnt), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .init_mem_addr(init_mem_addr), .init_mem_vld(init_mem_vld),
        .init_mem_wr_en(init_mem_wr_en), .init_mem_wr_data(init_mem_wr_data),
        .init_mem_rd_data(init_mem_rd_data), .init_mem_rd_data_vld(init_mem_rd_data_vld)
    );

    interconnect_xbar_gen #(.N_PE(NP), .N_BANKS(NB), .DATA_L(DL), .BANK_ADDR_L(BA),
                            .BANK_ID_LSB(0), .MEM_RD_LAT(2), .ST_PRIO(0)) dut_fair (
        .clk(clk), .rst(rst), .ld_addr(ld_addr), .ld_req(ld_req), .ld_gnt(f_ld_gnt),
        .ld_data(f_ld_data), .ld_data_vld(f_ld_data_vld), .st_addr(st_addr), .st_data(st_data),
        .st_req(st_req), .st_gnt(f_st_gnt), .mem_addr(f_mem_addr), .mem_wr_data(f_mem_wr_data),
        .mem_wr_en(f_mem_wr_en), .mem_rd_en(f_mem_rd_en), .mem_rd_data(zero_rd_data),
        .init_mem_addr(init_mem_addr), .init_mem_vld(init_mem_vld),
        .init_mem_wr_en(init_mem_wr_en), .init_mem_wr_data(init_mem_wr_data),
        .init_mem_rd_data(f_init_mem_rd_data), .init_mem_rd_data_vld(f_init_mem_rd_data_vld)
    );

    // Bank model with two-cycle registered read.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_wr_en[b]) begin
                mem[b][mem_addr[b*BA +: BA]] <= mem_wr_data[b*DL +: DL];
            end
            s0[b] <= mem[b][mem_addr[b*BA +: BA]];
            s1[b] <= s0[b];
        end
    end

    always_comb begin
        mem_rd_data = '0;
        for (int b = 0; b < NB; b++) begin
            mem_rd_data[b*DL +: DL] = s1[b];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic set_ld(input int i, input logic [GA-1:0] a);
        ld_addr[i*GA +: GA] = a;
    endtask

    task automatic set_st(input int i, input logic [GA-1:0] a, input logic [DL-1:0] d);
        st_addr[i*GA +: GA] = a;
        st_data[i*DL +: DL] = d;
    endtask

    initial begin
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < 1024; a++) begin
                mem[b][a] = 32'hA000_0000 | (b << 16) | a;
            end
            s0[b] = '0;
            s1[b] = '0;
        end
        rst = 1'b0;
        ld_addr = '0; st_addr = '0; st_data = '0; ld_req = '0; st_req = '0;
        zero_rd_data = '0;
        init_mem_addr = '0; init_mem_vld = 1'b0; init_mem_wr_en = 1'b0; init_mem_wr_data = '0;
        repeat (2) step();

        // Reset holds every output at zero even with a request pending
        set_ld(3, 13'h095);
        ld_req[3] = 1'b1;
        settle();
        check("rst_ld_gnt", 64'(ld_gnt), 64'h0);
        check("rst_rd_en", 64'(mem_rd_en), 64'h0);
        check("rst_mem_addr", 64'(mem_addr), 64'h0);
        check("rst_vld", 64'(ld_data_vld), 64'h0);
        check("rst_ld_data3", 64'(ld_data[3*DL +: DL]), 64'h0);
        check("rst_init_vld", 64'(init_mem_rd_data_vld), 64'h0);

        // PE3 load of bank 5, bank addr 0x12
        rst = 1'b1;
        settle();
        check("ld_gnt_pe3", 64'(ld_gnt), 64'h0008);
        check("rd_en_b5", 64'(mem_rd_en), 64'h20);
        check("addr_b5", 64'(mem_addr[5*BA +: BA]), 64'h12);
        step();
        ld_req[3] = 1'b0;
        settle();
        check("vld_after1", 64'(ld_data_vld), 64'h0);
        step();
        check("vld_after2", 64'(ld_data_vld), 64'h0008);
        check("data_after2", 64'(ld_data[3*DL +: DL]), 64'hA005_0012);
        step();
        check("vld_after3", 64'(ld_data_vld), 64'h0);
        check("data_held", 64'(ld_data[3*DL +: DL]), 64'hA005_0012);

        // Reset mid-flight drops the pending response
        ld_req[3] = 1'b1;
        settle();
        check("mid_gnt", 64'(ld_gnt), 64'h0008);
        step();
        ld_req[3] = 1'b0;
        rst = 1'b0;
        settle();
        check("mid_rst_data", 64'(ld_data[3*DL +: DL]), 64'h0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("mid_no_vld", 64'(ld_data_vld), 64'h0);
        end

        // Store priority: PE0 store then loads PE1, PE2, PE3, all bank 2
        reset_pulse();
        set_st(0, 13'h03A, 32'h1111_2222);
        set_ld(1, 13'h00A);
        set_ld(2, 13'h012);
        set_ld(3, 13'h01A);
        st_req[0] = 1'b1;
        ld_req[3:1] = 3'b111;
        settle();
        check("sp_st_gnt", 64'(st_gnt), 64'h1);
        check("sp_ld_gnt0", 64'(ld_gnt), 64'h0);
        check("sp_wr_en", 64'(mem_wr_en), 64'h04);
        check("sp_wr_data", 64'(mem_wr_data[2*DL +: DL]), 64'h1111_2222);
        step();
        st_req[0] = 1'b0;
        settle();
        check("sp_ld_pe1", 64'(ld_gnt), 64'h0002);
        step();
        ld_req[1] = 1'b0;
        settle();
        check("sp_ld_pe2", 64'(ld_gnt), 64'h0004);
        step();
        ld_req[2] = 1'b0;
        settle();
        check("sp_ld_pe3", 64'(ld_gnt), 64'h0008);
        step();
        ld_req = '0;

        // Fair mode: 16 PEs loading bank 0 are served cyclically
        reset_pulse();
        for (int i = 0; i < NP; i++) begin
            set_ld(i, 13'(i << 3));
        end
        ld_req = '1;
        for (int k = 0; k < NP; k++) begin
            settle();
            check("fair_cyclic", 64'(f_ld_gnt), 64'(16'h1 << k));
            step();
        end
        ld_req = '0;

        // Mode difference: PE0 load and PE1 store to bank 3 from reset pointers
        reset_pulse();
        set_ld(0, 13'h00B);
        set_st(1, 13'h013, 32'h0000_0055);
        ld_req[0] = 1'b1;
        st_req[1] = 1'b1;
        settle();
        check("mode_sp_st", 64'(st_gnt), 64'h0002);
        check("mode_sp_ld", 64'(ld_gnt), 64'h0);
        check("mode_fair", 64'({f_st_gnt, f_ld_gnt}), 64'h0000_0001);
        step();
        ld_req = '0;
        st_req = '0;

        // Same PE: load bank 1 plus store bank 4 both granted; same bank only one
        reset_pulse();
        set_ld(2, 13'h021);
        set_st(2, 13'h02C, 32'hCAFE_0001);
        ld_req[2] = 1'b1;
        st_req[2] = 1'b1;
        settle();
        check("dual_ld", 64'(ld_gnt), 64'h0004);
        check("dual_st", 64'(st_gnt), 64'h0004);
        check("dual_en", 64'({mem_rd_en, mem_wr_en}), 64'h0210);
        step();
        set_ld(2, 13'h00E);
        set_st(2, 13'h016, 32'hCAFE_0002);
        settle();
        check("same_sp", 64'({st_gnt, ld_gnt}), 64'h0004_0000);
        check("same_fair", 64'({f_st_gnt, f_ld_gnt}), 64'h0004_0000);
        step();
        st_req[2] = 1'b0;
        settle();
        check("same_ld_next", 64'(ld_gnt), 64'h0004);
        step();
        ld_req = '0;

        // Init write 0xDEADBEEF at 0x41 blocks PE load, then read back
        reset_pulse();
        set_ld(0, 13'h095);
        ld_req[0] = 1'b1;
        init_mem_vld = 1'b1;
        init_mem_wr_en = 1'b1;
        init_mem_addr = 13'h041;
        init_mem_wr_data = 32'hDEAD_BEEF;
        settle();
        check("init_ld_blk", 64'(ld_gnt), 64'h0);
        check("init_wr_en", 64'(mem_wr_en), 64'h02);
        check("init_addr", 64'(mem_addr[1*BA +: BA]), 64'h008);
        check("init_wdata", 64'(mem_wr_data[1*DL +: DL]), 64'hDEAD_BEEF);
        step();
        init_mem_wr_en = 1'b0;
        settle();
        check("init_rd_blk", 64'(ld_gnt), 64'h0);
        check("init_rd_en", 64'(mem_rd_en), 64'h02);
        step();
        init_mem_vld = 1'b0;
        settle();
        check("resume_gnt", 64'(ld_gnt), 64'h0001);
        check("init_vld_l1", 64'(init_mem_rd_data_vld), 64'h0);
        step();
        ld_req = '0;
        settle();
        check("init_vld_l2", 64'(init_mem_rd_data_vld), 64'h1);
        check("init_rdata", 64'(init_mem_rd_data), 64'hDEAD_BEEF);
        step();
        check("resume_vld", 64'(ld_data_vld), 64'h0001);
        check("resume_data", 64'(ld_data[0 +: DL]), 64'hA005_0012);
        check("init_vld_off", 64'(init_mem_rd_data_vld), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
